// File: rtl/issue_stage_pkg.sv
// Shared types for the dual-issue pairing stage: the decoded instruction
// record, memory-op kinds, the pairing FSM states and a register-hazard helper.
package issue_stage_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    MEM_NONE   = 2'd0,
    MEM_LOAD   = 2'd1,
    MEM_STORE  = 2'd2,
    MEM_ATOMIC = 2'd3
  } mem_type_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PAIR   = 2'd1,
    SOLO_B = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic             have_exception;
    logic [3:0]       exception_type;
    logic [7:0]       opcode;
    logic [REG_W-1:0] rf_src1;
    logic [REG_W-1:0] rf_src2;
    logic             src2_is_imm;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] dest;
    logic             is_branch;
    logic             br_pred_taken;
    logic [XLEN-1:0]  br_target;
    logic             pred_en;
    logic [2:0]       pred_idx;
    mem_type_t        mem_type;
    logic [1:0]       mem_size;
    logic             is_spec_op;
    logic [3:0]       spec_opcode;
    logic             branch_mistaken;
  } decoded_inst_t;

  // r0 is hardwired zero, so writing it never creates a dependency.
  function automatic logic reads_reg(input decoded_inst_t inst, input logic [REG_W-1:0] r);
    return (r != '0) &&
           ((inst.rf_src1 == r) || (!inst.src2_is_imm && (inst.rf_src2 == r)));
  endfunction

endpackage

// File: rtl/issue_stage_if.sv
// Decoder-pair input and read-operands output lanes of the issue stage.
interface issue_stage_if;
  import issue_stage_pkg::*;

  // Input handshake: a pair transfers on a rising clk where in_valid && in_ready.
  // in_valid must not depend on in_ready; in_a is always meaningful when in_valid,
  // in_b only when in_b_valid. Output lanes carry no back-pressure here: the
  // consumer holds ro_stall instead, and id_*_ready mark which lanes are valid.
  logic          in_valid;
  logic          in_ready;
  logic          in_b_valid;
  decoded_inst_t in_a;
  decoded_inst_t in_b;

  logic          id_a_ready;
  decoded_inst_t id_a;
  logic          id_b_ready;
  decoded_inst_t id_b;

  modport master (
    output in_valid, in_b_valid, in_a, in_b,
    input  in_ready, id_a_ready, id_a, id_b_ready, id_b
  );

  modport slave (
    input  in_valid, in_b_valid, in_a, in_b,
    output in_ready, id_a_ready, id_a, id_b_ready, id_b
  );

endinterface

// File: rtl/issue_stage_pair_checker.sv
// Combinational check of whether the younger instruction may issue beside the
// older one in the same cycle.
module pair_checker
  import issue_stage_pkg::*;
#(
  parameter bit ALLOW_DUAL_MEM  = 1'b0,
  parameter bit ALLOW_DUAL_SPEC = 1'b0
) (
  input  decoded_inst_t a,
  input  decoded_inst_t b,
  output logic          conflict
);

  logic raw_hazard;
  logic mem_clash;
  logic spec_clash;

  always_comb begin
    raw_hazard = reads_reg(b, a.dest);
    mem_clash  = (a.mem_type != MEM_NONE) && (b.mem_type != MEM_NONE) && !ALLOW_DUAL_MEM;
    spec_clash = (a.is_spec_op || b.is_spec_op) && !ALLOW_DUAL_SPEC;
    // An excepting A must reach commit alone so B cannot slip past it.
    conflict   = raw_hazard || mem_clash || spec_clash || a.have_exception;
  end

endmodule

// File: rtl/issue_stage.sv
// Dual-issue pairing stage: holds one decoded pair and presents it to the
// read-operands stage, splitting it over two cycles when B cannot ride with A.
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter bit ALLOW_DUAL_MEM  = 1'b0,
  parameter bit ALLOW_DUAL_SPEC = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         ro_stall,
  issue_stage_if.slave bus,
  output issue_state_t dbg_state
);

  issue_state_t  state_q, state_d;
  decoded_inst_t a_q, a_d;
  decoded_inst_t b_q, b_d;
  logic          b_held_q, b_held_d;

  logic conflict;
  logic advance;
  logic split;
  logic drain;
  logic in_ready_c;
  logic accept;

  pair_checker #(
    .ALLOW_DUAL_MEM  (ALLOW_DUAL_MEM),
    .ALLOW_DUAL_SPEC (ALLOW_DUAL_SPEC)
  ) u_pair_checker (
    .a        (a_q),
    .b        (b_q),
    .conflict (conflict)
  );

  // A mistaken branch discards B outright, so it never forces a split.
  always_comb begin
    advance    = !ro_stall;
    split      = (state_q == PAIR) && b_held_q && conflict && !a_q.branch_mistaken;
    drain      = advance && (((state_q == PAIR) && !split) || (state_q == SOLO_B));
    in_ready_c = (state_q == EMPTY) || drain;
    accept     = bus.in_valid && in_ready_c && !flush;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    b_held_d = b_held_q;

    if (accept) begin
      a_d      = bus.in_a;
      b_d      = bus.in_b;
      b_held_d = bus.in_b_valid;
    end

    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) state_d = PAIR;
        end
        PAIR: begin
          if (advance) begin
            if (split)       state_d = SOLO_B;
            else if (accept) state_d = PAIR;
            else             state_d = EMPTY;
          end
        end
        SOLO_B: begin
          if (advance) state_d = accept ? PAIR : EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Payload registers carry no reset; state alone decides what is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      b_held_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_held_q <= b_held_d;
    end
    a_q <= a_d;
    b_q <= b_d;
  end

  // Lane A always shows the oldest unissued instruction.
  assign bus.in_ready   = in_ready_c;
  assign bus.id_a_ready = (state_q != EMPTY);
  assign bus.id_a       = (state_q == SOLO_B) ? b_q : a_q;
  assign bus.id_b_ready = (state_q == PAIR) && b_held_q && !conflict && !a_q.branch_mistaken;
  assign bus.id_b       = b_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: two instances (strict pairing and permissive pairing)
// share one input stream and are each checked against an instruction-queue model.
module tb_issue_stage;
  import issue_stage_pkg::*;

  localparam int IW = $bits(decoded_inst_t);

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         ro_stall;
  issue_state_t dbg0, dbg1;

  int tests = 0;
  int fails = 0;

  // Model: the unissued instructions of each instance, oldest first.
  decoded_inst_t mbuf [2][2];
  int            mcnt [2];

  issue_stage_if bus0 ();
  issue_stage_if bus1 ();

  issue_stage #(.ALLOW_DUAL_MEM(1'b0), .ALLOW_DUAL_SPEC(1'b0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .ro_stall  (ro_stall),
    .bus       (bus0),
    .dbg_state (dbg0)
  );

  issue_stage #(.ALLOW_DUAL_MEM(1'b1), .ALLOW_DUAL_SPEC(1'b1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .ro_stall  (ro_stall),
    .bus       (bus1),
    .dbg_state (dbg1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int m, input logic [IW-1:0] obs,
                       input logic [IW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, m, obs, exp);
    end
  endtask

  function automatic logic m_conflict(input decoded_inst_t a, input decoded_inst_t b,
                                      input bit dual_mem, input bit dual_spec);
    logic raw;
    raw = (a.dest != 5'd0) &&
          ((b.rf_src1 == a.dest) || (!b.src2_is_imm && (b.rf_src2 == a.dest)));
    return raw ||
           ((a.mem_type != MEM_NONE) && (b.mem_type != MEM_NONE) && !dual_mem) ||
           ((a.is_spec_op || b.is_spec_op) && !dual_spec) ||
           a.have_exception;
  endfunction

  function automatic decoded_inst_t mk(input logic [31:0] pc, input logic [4:0] dest,
                                       input logic [4:0] s1, input logic [4:0] s2);
    decoded_inst_t t;
    t         = '0;
    t.pc      = pc;
    t.opcode  = 8'h33;
    t.dest    = dest;
    t.rf_src1 = s1;
    t.rf_src2 = s2;
    return t;
  endfunction

  function automatic decoded_inst_t rand_inst(input logic [31:0] pc);
    decoded_inst_t t;
    t                 = mk(pc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)));
    t.opcode          = 8'($urandom);
    t.imm             = $urandom;
    t.src2_is_imm     = 1'($urandom_range(0, 1));
    t.mem_type        = mem_type_t'(2'($urandom_range(0, 3)));
    t.mem_size        = 2'($urandom_range(0, 3));
    t.is_spec_op      = ($urandom_range(0, 7) == 0);
    t.spec_opcode     = 4'($urandom);
    t.have_exception  = ($urandom_range(0, 15) == 0);
    t.branch_mistaken = ($urandom_range(0, 7) == 0);
    return t;
  endfunction

  // One clock: drive inputs at negedge, check outputs, advance the model, pass posedge.
  task automatic step(input bit fl, input bit st, input bit iv, input bit bv,
                      input decoded_inst_t a, input decoded_inst_t b);
    int            n;
    bit            exp_b;
    bit            exp_in_rdy;
    logic          o_a_rdy, o_b_rdy, o_in_rdy;
    decoded_inst_t o_a, o_b;
    issue_state_t  o_st;
    @(negedge clk);
    flush    = fl;
    ro_stall = st;
    bus0.in_valid = iv; bus0.in_b_valid = bv; bus0.in_a = a; bus0.in_b = b;
    bus1.in_valid = iv; bus1.in_b_valid = bv; bus1.in_a = a; bus1.in_b = b;
    #1;
    for (int m = 0; m < 2; m++) begin
      if (m == 0) begin
        o_a_rdy = bus0.id_a_ready; o_b_rdy = bus0.id_b_ready; o_in_rdy = bus0.in_ready;
        o_a = bus0.id_a; o_b = bus0.id_b; o_st = dbg0;
      end else begin
        o_a_rdy = bus1.id_a_ready; o_b_rdy = bus1.id_b_ready; o_in_rdy = bus1.in_ready;
        o_a = bus1.id_a; o_b = bus1.id_b; o_st = dbg1;
      end
      n = mcnt[m];
      exp_b = 1'b0;
      if (n == 2) exp_b = !m_conflict(mbuf[m][0], mbuf[m][1], m == 1, m == 1);
      exp_in_rdy = (n == 0) || (!st && ((n == 1) || exp_b));

      check("id_a_ready", m, IW'(o_a_rdy), IW'(n > 0));
      check("id_b_ready", m, IW'(o_b_rdy), IW'(exp_b));
      check("state_empty", m, IW'(o_st == EMPTY), IW'(n == 0));
      if (n > 0) check("id_a", m, IW'(o_a), IW'(mbuf[m][0]));
      if (exp_b) check("id_b", m, IW'(o_b), IW'(mbuf[m][1]));
      if (!fl)   check("in_ready", m, IW'(o_in_rdy), IW'(exp_in_rdy));

      if (fl) begin
        mcnt[m] = 0;
      end else begin
        if (!st && (n > 0)) begin
          if ((n == 2) && !exp_b) begin
            mbuf[m][0] = mbuf[m][1];
            mcnt[m]    = 1;
          end else begin
            mcnt[m] = 0;
          end
        end
        if (iv && exp_in_rdy) begin
          mbuf[m][0] = a;
          mcnt[m]    = 1;
          if (bv && !a.branch_mistaken) begin
            mbuf[m][1] = b;
            mcnt[m]    = 2;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    flush    = 1'b0;
    ro_stall = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_b_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0;
    bus1.in_valid = 1'b0; bus1.in_b_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    mcnt[0] = 0;
    mcnt[1] = 0;
  endtask

  initial begin
    decoded_inst_t z, a, b;
    z = '0;
    reset = 1'b1;
    mcnt[0] = 0;
    mcnt[1] = 0;
    do_reset();

    // Reset state
    check("rst_in_ready", 0, IW'(bus0.in_ready), IW'(1'b1));
    check("rst_id_a_ready", 0, IW'(bus0.id_a_ready), IW'(1'b0));
    step(0, 0, 0, 0, z, z);

    // Independent pairs back to back
    step(0, 0, 1, 1, mk(32'h100, 5'd4, 5'd1, 5'd2), mk(32'h104, 5'd5, 5'd6, 5'd7));
    step(0, 0, 1, 1, mk(32'h108, 5'd8, 5'd1, 5'd2), mk(32'h10c, 5'd9, 5'd6, 5'd7));
    check("t1_no_bubble_pc", 0, IW'(bus0.id_a.pc), IW'(32'h108));
    check("t1_no_bubble_b", 0, IW'(bus0.id_b_ready), IW'(1'b1));
    step(0, 0, 0, 0, z, z);
    step(0, 0, 0, 0, z, z);

    // RAW split
    step(0, 0, 1, 1, mk(32'h200, 5'd4, 5'd1, 5'd2), mk(32'h204, 5'd5, 5'd4, 5'd6));
    check("t2_a_pc", 0, IW'(bus0.id_a.pc), IW'(32'h200));
    check("t2_b_held_back", 0, IW'(bus0.id_b_ready), IW'(1'b0));
    step(0, 0, 0, 0, z, z);
    check("t2_solo_b_pc", 0, IW'(bus0.id_a.pc), IW'(32'h204));
    check("t2_solo_b_b", 0, IW'(bus0.id_b_ready), IW'(1'b0));
    step(0, 0, 0, 0, z, z);
    step(0, 0, 0, 0, z, z);

    // Split under stall, with a pair waiting at the input
    step(0, 0, 1, 1, mk(32'h300, 5'd4, 5'd1, 5'd2), mk(32'h304, 5'd5, 5'd4, 5'd6));
    step(0, 0, 0, 0, z, z);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, mk(32'h400, 5'd1, 5'd2, 5'd3), mk(32'h404, 5'd2, 5'd3, 5'd4));
      check("t3_stall_hold_pc", 0, IW'(bus0.id_a.pc), IW'(32'h304));
    end
    step(0, 0, 0, 0, z, z);
    step(0, 0, 0, 0, z, z);

    // Mistaken branch drops B
    a = mk(32'h500, 5'd4, 5'd1, 5'd2);
    a.is_branch = 1'b1;
    a.branch_mistaken = 1'b1;
    step(0, 0, 1, 1, a, mk(32'h504, 5'd5, 5'd6, 5'd7));
    check("t4_no_b", 0, IW'(bus0.id_b_ready), IW'(1'b0));
    check("t4_no_b", 1, IW'(bus1.id_b_ready), IW'(1'b0));
    step(0, 0, 0, 0, z, z);
    check("t4_empty", 0, IW'(dbg0 == EMPTY), IW'(1'b1));
    step(0, 0, 0, 0, z, z);

    // Flush in SOLO_B with a pair presented
    step(0, 0, 1, 1, mk(32'h600, 5'd4, 5'd1, 5'd2), mk(32'h604, 5'd5, 5'd4, 5'd6));
    step(0, 0, 0, 0, z, z);
    step(1, 0, 1, 1, mk(32'h700, 5'd1, 5'd2, 5'd3), mk(32'h704, 5'd2, 5'd3, 5'd4));
    check("t5_flush_a", 0, IW'(bus0.id_a_ready), IW'(1'b0));
    check("t5_flush_b", 0, IW'(bus0.id_b_ready), IW'(1'b0));
    step(0, 0, 0, 0, z, z);

    // Dual mem: strict instance splits, permissive instance pairs
    a = mk(32'h800, 5'd9, 5'd1, 5'd0);
    a.mem_type = MEM_LOAD;
    b = mk(32'h804, 5'd0, 5'd2, 5'd3);
    b.mem_type = MEM_STORE;
    step(0, 0, 1, 1, a, b);
    check("t6_mem_split", 0, IW'(bus0.id_b_ready), IW'(1'b0));
    check("t6_mem_pair", 1, IW'(bus1.id_b_ready), IW'(1'b1));
    step(0, 0, 0, 0, z, z);
    step(0, 0, 0, 0, z, z);

    // Immediate operand does not count as a read of a.dest
    b = mk(32'h904, 5'd5, 5'd1, 5'd4);
    b.src2_is_imm = 1'b1;
    step(0, 0, 1, 1, mk(32'h900, 5'd4, 5'd1, 5'd2), b);
    check("t6_imm_pair", 0, IW'(bus0.id_b_ready), IW'(1'b1));
    step(0, 0, 0, 0, z, z);

    // No B: never splits even if B's fields would conflict
    step(0, 0, 1, 0, mk(32'ha00, 5'd4, 5'd1, 5'd2), mk(32'ha04, 5'd5, 5'd4, 5'd4));
    step(0, 0, 0, 0, z, z);
    check("t7_no_b_empty", 0, IW'(dbg0 == EMPTY), IW'(1'b1));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      if (i == 300) do_reset();
      pc = 32'h1000 + 32'(i) * 32'd8;
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           rand_inst(pc), rand_inst(pc + 32'd4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
